// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - push-switch synchroniser and prescaled debounce FSM
// Emits a clean level plus one-cycle press/release pulses.
module sw_debounce #(
    parameter int SAMPLE_DIV = 4,
    parameter int STABLE_N   = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_IN,
    output logic SW_LVL,
    output logic SW_PRESS,
    output logic SW_REL
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(STABLE_N + 1);
    localparam logic [PW-1:0] PMAX = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] SMAX = CW'(STABLE_N);

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CHK_HI = 2'd1,
        S_HIGH   = 2'd2,
        S_CHK_LO = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic [PW-1:0] r_pcnt;
    logic [CW-1:0] r_scnt;
    state_t        r_state;
    logic          r_lvl;
    logic          r_press;
    logic          r_rel;

    logic          w_tick;
    logic [CW-1:0] w_scnt_inc;

    assign w_tick     = (r_pcnt == PMAX);
    assign w_scnt_inc = r_scnt + CW'(1);

    assign SW_LVL   = r_lvl;
    assign SW_PRESS = r_press;
    assign SW_REL   = r_rel;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= SW_IN;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pcnt <= '0;
        end else if (r_pcnt == PMAX) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // Pulses clear every cycle; everything else moves only on a sample tick.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_LOW;
            r_scnt  <= '0;
            r_lvl   <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_LOW: begin
                        if (r_sync2) begin
                            r_state <= S_CHK_HI;
                            r_scnt  <= CW'(1);
                        end
                    end
                    S_CHK_HI: begin
                        if (!r_sync2) begin
                            r_state <= S_LOW;
                            r_scnt  <= '0;
                        end else if (w_scnt_inc == SMAX) begin
                            r_state <= S_HIGH;
                            r_scnt  <= '0;
                            r_lvl   <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_scnt  <= w_scnt_inc;
                        end
                    end
                    S_HIGH: begin
                        if (!r_sync2) begin
                            r_state <= S_CHK_LO;
                            r_scnt  <= CW'(1);
                        end
                    end
                    S_CHK_LO: begin
                        if (r_sync2) begin
                            r_state <= S_HIGH;
                            r_scnt  <= '0;
                        end else if (w_scnt_inc == SMAX) begin
                            r_state <= S_LOW;
                            r_scnt  <= '0;
                            r_lvl   <= 1'b0;
                            r_rel   <= 1'b1;
                        end else begin
                            r_scnt  <= w_scnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_LOW;
                        r_scnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench for sw_debounce
// Edge n counts rising edges since reset release; sample ticks fall on n%4==0.
module tb_sw_debounce;

    logic CLK;
    logic RST;
    logic SW_IN;
    logic SW_LVL;
    logic SW_PRESS;
    logic SW_REL;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic exp_lvl = 1'b0;

    typedef struct {
        int         edge_n;
        logic [1:0] kind;
    } ev_t;

    ev_t q[$];

    sw_debounce #(
        .SAMPLE_DIV(4),
        .STABLE_N  (3)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SW_IN   (SW_IN),
        .SW_LVL  (SW_LVL),
        .SW_PRESS(SW_PRESS),
        .SW_REL  (SW_REL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST) begin
        if (!RST) n <= 0;
        else      n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic push(input int edge_n, input logic [1:0] kind);
        ev_t ev;
        ev.edge_n = edge_n;
        ev.kind   = kind;
        q.push_back(ev);
    endtask

    task automatic wait_n(input int k);
        int guard = 0;
        while (n != k && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 1000) check("wait_timeout", n, k);
    endtask

    task automatic drive(input int k, input logic v);
        wait_n(k - 1);
        SW_IN = v;
    endtask

    // Monitor: pulses are matched against the expected-event queue (kind, edge).
    always @(negedge CLK) begin
        ev_t ev;
        if (!RST) begin
            check("reset_outputs", {29'd0, SW_LVL, SW_PRESS, SW_REL}, 32'd0);
            exp_lvl = 1'b0;
        end else begin
            if (SW_PRESS || SW_REL) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, SW_PRESS, SW_REL}, 32'd0);
                end else begin
                    ev = q.pop_front();
                    check("pulse_kind", {30'd0, SW_PRESS, SW_REL}, {30'd0, ev.kind});
                    check("pulse_edge", n, ev.edge_n);
                    exp_lvl = ev.kind[1];
                end
            end else if (q.size() > 0 && n > q[0].edge_n) begin
                ev = q.pop_front();
                check("missed_pulse_edge", n, ev.edge_n);
                exp_lvl = ev.kind[1];
            end
            check("level", {31'd0, SW_LVL}, {31'd0, exp_lvl});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        RST   = 1'b0;
        SW_IN = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            SW_IN = ~SW_IN;
        end
        @(negedge CLK);
        SW_IN = 1'b0;
        #2 RST = 1'b1;

        // clean press, worst-case alignment: 13 edges to the pulse
        drive(23, 1'b1);
        push(36, 2'b10);

        // 5-cycle low glitch while high: two CHK_LO samples, then back to HIGH
        drive(50, 1'b0);
        drive(55, 1'b1);

        // release
        drive(70, 1'b0);
        push(80, 2'b01);

        // bouncing press 1,0,1,0 (2 cycles each) then steady 1
        drive(91, 1'b1);
        drive(93, 1'b0);
        drive(95, 1'b1);
        drive(97, 1'b0);
        drive(99, 1'b1);
        push(112, 2'b10);

        drive(122, 1'b0);
        push(132, 2'b01);

        // 5-cycle high glitch while low: CHK_HI seen twice, then rejected
        drive(142, 1'b1);
        drive(147, 1'b0);

        // reset while CHK_HI with SCNT=2, switch held high through reset
        drive(162, 1'b1);
        wait_n(170);
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        push(12, 2'b10);

        // asynchronous reset from HIGH must clear the level without a clock edge
        wait_n(20);
        #2 RST = 1'b0;
        #1 check("async_reset_level", {31'd0, SW_LVL}, 32'd0);
        repeat (2) @(negedge CLK);
        SW_IN = 1'b0;
        #2 RST = 1'b1;
        repeat (20) @(negedge CLK);

        check("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
